// File: rtl/uart_transmit_controller_if.sv
// Byte handshake between the register side (master) and the UART transmitter (slave).
interface uart_transmit_controller_if #(
    parameter int C_DATA_BITS = 8
);
    logic [C_DATA_BITS-1:0] TX_DATA;
    logic                   TX_VALID;
    logic                   TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_transmit_controller.sv
// UART TX: FIFO-buffered bytes serialized as start/data(LSB first)/parity/stop, one-cycle Interrupt on drain.
// Optional UART_TX_BREAK_EN adds TX_BREAK: holds TX low and blocks pops once the current frame has finished.
module uart_transmit_controller #(
    parameter int C_S_AXI_ACLK_FREQ_HZ = 100_000_000,
    parameter int C_BAUDRATE           = 9600,
    parameter int C_DATA_BITS          = 8,
    parameter int C_USE_PARITY         = 0,
    parameter int C_ODD_PARITY         = 0,
    parameter int C_FIFO_DEPTH         = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
`ifdef UART_TX_BREAK_EN
    input  logic                            TX_BREAK,
`endif
    uart_transmit_controller_if.slave       tx_if,
    output logic                            TX_FIFO_FULL,
    output logic                            TX_FIFO_EMPTY,
    output logic [$clog2(C_FIFO_DEPTH):0]   TX_COUNT,
    output logic                            TX_BUSY,
    output logic                            Interrupt,
    output logic                            TX
);
    localparam int   DIV     = C_S_AXI_ACLK_FREQ_HZ / C_BAUDRATE;
    localparam int   CW      = $clog2(DIV);
    localparam int   PW      = $clog2(C_FIFO_DEPTH);
    localparam int   CNTW    = PW + 1;
    localparam int   BW      = $clog2(C_DATA_BITS);
    localparam logic ODD_BIT = (C_ODD_PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [C_DATA_BITS-1:0] mem_q [C_FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]        count_q, count_d;
    state_t                 state_q;
    logic [CW-1:0]          baud_q;
    logic [BW-1:0]          bit_q;
    logic [C_DATA_BITS-1:0] sh_q;
    logic                   par_q, tx_q, irq_q;
    logic                   push, pop, baud_done, brk_block;
    logic [C_DATA_BITS-1:0] head;

`ifdef UART_TX_BREAK_EN
    // Set while a break is held; keeps the line idle for one bit period after release.
    logic brk_wait_q;
    assign brk_block = TX_BREAK | brk_wait_q;
`else
    assign brk_block = 1'b0;
`endif

    assign TX_FIFO_EMPTY  = (count_q == '0);
    assign TX_FIFO_FULL   = (count_q == CNTW'(C_FIFO_DEPTH));
    assign tx_if.TX_READY = ~TX_FIFO_FULL;
    assign TX_COUNT       = count_q;
    assign TX_BUSY        = (state_q != S_IDLE);
    assign Interrupt      = irq_q;
    assign TX             = tx_q;

    assign head      = mem_q[rd_ptr_q];
    assign baud_done = (baud_q == CW'(DIV - 1));
    assign push      = tx_if.TX_VALID & ~TX_FIFO_FULL;
    assign pop       = ~TX_FIFO_EMPTY & ~brk_block &
                       ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_done));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_if.TX_DATA;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_wait_q <= 1'b0;
`endif
        end else begin
            irq_q <= 1'b0;
            if (pop) begin
                state_q <= S_START;
                baud_q  <= '0;
                sh_q    <= head;
                par_q   <= (^head) ^ ODD_BIT;
                tx_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                        tx_q <= ~TX_BREAK;
                        if (TX_BREAK) begin
                            brk_wait_q <= 1'b1;
                            baud_q     <= '0;
                        end else if (brk_wait_q) begin
                            if (baud_done) begin
                                brk_wait_q <= 1'b0;
                                baud_q     <= '0;
                            end else begin
                                baud_q <= baud_q + CW'(1);
                            end
                        end
`else
                        tx_q   <= 1'b1;
                        baud_q <= '0;
`endif
                    end
                    S_START: begin
                        if (baud_done) begin
                            state_q <= S_DATA;
                            baud_q  <= '0;
                            bit_q   <= '0;
                            tx_q    <= sh_q[0];
                            sh_q    <= sh_q >> 1;
                        end else begin
                            baud_q <= baud_q + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (baud_done) begin
                            baud_q <= '0;
                            if (bit_q == BW'(C_DATA_BITS - 1)) begin
                                if (C_USE_PARITY != 0) begin
                                    state_q <= S_PARITY;
                                    tx_q    <= par_q;
                                end else begin
                                    state_q <= S_STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                bit_q <= bit_q + BW'(1);
                                tx_q  <= sh_q[0];
                                sh_q  <= sh_q >> 1;
                            end
                        end else begin
                            baud_q <= baud_q + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (baud_done) begin
                            state_q <= S_STOP;
                            baud_q  <= '0;
                            tx_q    <= 1'b1;
                        end else begin
                            baud_q <= baud_q + CW'(1);
                        end
                    end
                    S_STOP: begin
                        // Reaching here at baud_done means no pop: either drained or held by a break.
                        if (baud_done) begin
                            state_q <= S_IDLE;
                            baud_q  <= '0;
                            irq_q   <= TX_FIFO_EMPTY;
                        end else begin
                            baud_q <= baud_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_transmit_controller.sv
// Directed bench: DIV=10, depth 4; instance a has no parity, b even parity, c odd parity.
module tb_uart_transmit_controller;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_transmit_controller_if #(.C_DATA_BITS(8)) a_if ();
    uart_transmit_controller_if #(.C_DATA_BITS(8)) b_if ();
    uart_transmit_controller_if #(.C_DATA_BITS(8)) c_if ();

    logic       a_full, a_empty, a_busy, a_irq, a_tx;
    logic       b_full, b_empty, b_busy, b_irq, b_tx;
    logic       c_full, c_empty, c_busy, c_irq, c_tx;
    logic [2:0] a_cnt, b_cnt, c_cnt;
`ifdef UART_TX_BREAK_EN
    logic brk = 1'b0;
`endif

    uart_transmit_controller #(.C_S_AXI_ACLK_FREQ_HZ(100), .C_BAUDRATE(10), .C_DATA_BITS(8),
        .C_USE_PARITY(0), .C_ODD_PARITY(0), .C_FIFO_DEPTH(4)) dut_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
`ifdef UART_TX_BREAK_EN
        .TX_BREAK(brk),
`endif
        .tx_if(a_if), .TX_FIFO_FULL(a_full), .TX_FIFO_EMPTY(a_empty), .TX_COUNT(a_cnt),
        .TX_BUSY(a_busy), .Interrupt(a_irq), .TX(a_tx));

    uart_transmit_controller #(.C_S_AXI_ACLK_FREQ_HZ(100), .C_BAUDRATE(10), .C_DATA_BITS(8),
        .C_USE_PARITY(1), .C_ODD_PARITY(0), .C_FIFO_DEPTH(4)) dut_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
`ifdef UART_TX_BREAK_EN
        .TX_BREAK(brk),
`endif
        .tx_if(b_if), .TX_FIFO_FULL(b_full), .TX_FIFO_EMPTY(b_empty), .TX_COUNT(b_cnt),
        .TX_BUSY(b_busy), .Interrupt(b_irq), .TX(b_tx));

    uart_transmit_controller #(.C_S_AXI_ACLK_FREQ_HZ(100), .C_BAUDRATE(10), .C_DATA_BITS(8),
        .C_USE_PARITY(1), .C_ODD_PARITY(1), .C_FIFO_DEPTH(4)) dut_c (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
`ifdef UART_TX_BREAK_EN
        .TX_BREAK(brk),
`endif
        .tx_if(c_if), .TX_FIFO_FULL(c_full), .TX_FIFO_EMPTY(c_empty), .TX_COUNT(c_cnt),
        .TX_BUSY(c_busy), .Interrupt(c_irq), .TX(c_tx));

    task automatic test_reset();
        rst = 1'b1;
        a_if.TX_VALID = 1'b0; a_if.TX_DATA = 8'h00;
        b_if.TX_VALID = 1'b0; b_if.TX_DATA = 8'h00;
        c_if.TX_VALID = 1'b0; c_if.TX_DATA = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (a_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", a_tx); end
        total++; if (a_if.TX_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_if.TX_READY); end
        total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", a_cnt); end
        total++; if (a_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", a_irq); end
        total++; if ({a_empty, a_full, a_busy} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b want=100", {a_empty, a_full, a_busy}); end
        total++; if ({b_tx, c_tx} !== 2'b11) begin bad++; $display("FAIL reset_tx_bc got=%b want=11", {b_tx, c_tx}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({a_tx, a_busy, a_cnt} !== {1'b1, 1'b0, 3'd0}) begin bad++; $display("FAIL post_reset_idle tx/busy/cnt got=%b/%b/%0d want=1/0/0", a_tx, a_busy, a_cnt); end
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_f;
        int irqs;
        exp_f = 10'b1101001010;  // stop, A5 MSB..LSB, start
        irqs = 0;
        a_if.TX_VALID = 1'b1; a_if.TX_DATA = 8'hA5;
        @(negedge clk);
        a_if.TX_VALID = 1'b0;
        total++; if ({a_tx, a_cnt} !== {1'b1, 3'd1}) begin bad++; $display("FAIL single_accept tx/cnt got=%b/%0d want=1/1", a_tx, a_cnt); end
        @(negedge clk);
        total++; if ({a_cnt, a_busy} !== {3'd0, 1'b1}) begin bad++; $display("FAIL single_pop cnt/busy got=%0d/%b want=0/1", a_cnt, a_busy); end
        for (int k = 0; k < 100; k++) begin
            total++; if (a_tx !== exp_f[k/10]) begin bad++; $display("FAIL single_tx k=%0d got=%b want=%b", k, a_tx, exp_f[k/10]); end
            if (a_irq === 1'b1) irqs++;
            @(negedge clk);
        end
        total++; if (irqs != 0) begin bad++; $display("FAIL single_irq_early got=%0d want=0", irqs); end
        total++; if ({a_irq, a_busy, a_tx} !== 3'b101) begin bad++; $display("FAIL single_end irq/busy/tx got=%b want=101", {a_irq, a_busy, a_tx}); end
        @(negedge clk);
        total++; if (a_irq !== 1'b0) begin bad++; $display("FAIL single_irq_width got=%b want=0", a_irq); end
    endtask

    task automatic test_parity();
        logic [10:0] exp_even, exp_odd;
        exp_even = 11'b11000001110;
        exp_odd  = 11'b10000001110;
        b_if.TX_VALID = 1'b1; b_if.TX_DATA = 8'h07;
        c_if.TX_VALID = 1'b1; c_if.TX_DATA = 8'h07;
        @(negedge clk);
        b_if.TX_VALID = 1'b0; c_if.TX_VALID = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 110; k++) begin
            total++; if (b_tx !== exp_even[k/10]) begin bad++; $display("FAIL parity_even k=%0d got=%b want=%b", k, b_tx, exp_even[k/10]); end
            total++; if (c_tx !== exp_odd[k/10]) begin bad++; $display("FAIL parity_odd k=%0d got=%b want=%b", k, c_tx, exp_odd[k/10]); end
            @(negedge clk);
        end
        total++; if ({b_irq, c_irq, b_busy, c_busy} !== 4'b1100) begin bad++; $display("FAIL parity_end irq/busy got=%b want=1100", {b_irq, c_irq, b_busy, c_busy}); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_s;
        int irqs;
        exp_s = {10'b1000011110, 10'b1010101010};  // 0x0F frame after 0x55 frame
        irqs = 0;
        a_if.TX_VALID = 1'b1; a_if.TX_DATA = 8'h55;
        @(negedge clk);
        a_if.TX_DATA = 8'h0F;
        @(negedge clk);
        a_if.TX_VALID = 1'b0;
        total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL b2b_push_pop_count got=%0d want=1", a_cnt); end
        for (int k = 0; k < 200; k++) begin
            total++; if (a_tx !== exp_s[k/10]) begin bad++; $display("FAIL b2b_tx k=%0d got=%b want=%b", k, a_tx, exp_s[k/10]); end
            if (a_irq === 1'b1) irqs++;
            @(negedge clk);
        end
        total++; if (irqs != 0) begin bad++; $display("FAIL b2b_irq_between got=%0d want=0", irqs); end
        total++; if ({a_irq, a_busy} !== 2'b10) begin bad++; $display("FAIL b2b_end irq/busy got=%b want=10", {a_irq, a_busy}); end
        @(negedge clk);
    endtask

    task automatic test_full_wrap();
        logic [7:0] fb [6];
        logic [7:0] cur;
        logic       last_rdy, eb;
        int idx, k, maxc, rdy_low, rdy_full, irqs, b;
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h5A; fb[5] = 8'h66;
        idx = 0; maxc = 0; rdy_low = 0; rdy_full = 0; irqs = 0;
        last_rdy = 1'b1;
        for (int j = 0; j < 603; j++) begin
            if (j > 0 && a_if.TX_VALID && last_rdy) idx++;
            a_if.TX_VALID = (idx < 6);
            a_if.TX_DATA  = (idx < 6) ? fb[idx] : 8'h00;
            last_rdy = a_if.TX_READY;
            if (int'(a_cnt) > maxc) maxc = int'(a_cnt);
            if (!a_if.TX_READY) rdy_low++;
            if (a_cnt == 3'd4 && a_if.TX_READY) rdy_full++;
            if (j == 101) begin
                total++; if (idx != 5) begin bad++; $display("FAIL wrap_held_before_pop idx got=%0d want=5", idx); end
            end
            if (j >= 2 && j < 602) begin
                k = j - 2;
                cur = fb[k/100];
                b = (k % 100) / 10;
                eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                total++; if (a_tx !== eb) begin bad++; $display("FAIL wrap_tx k=%0d got=%b want=%b", k, a_tx, eb); end
                if (a_irq === 1'b1) irqs++;
            end
            if (j == 602) begin
                total++; if ({a_irq, a_busy, a_empty} !== 3'b101) begin bad++; $display("FAIL wrap_end irq/busy/empty got=%b want=101", {a_irq, a_busy, a_empty}); end
            end
            @(negedge clk);
        end
        a_if.TX_VALID = 1'b0;
        total++; if (maxc != 4) begin bad++; $display("FAIL wrap_max_count got=%0d want=4", maxc); end
        total++; if (rdy_low == 0) begin bad++; $display("FAIL wrap_ready_drop got=%0d want>0", rdy_low); end
        total++; if (rdy_full != 0) begin bad++; $display("FAIL wrap_ready_when_full got=%0d want=0", rdy_full); end
        total++; if (idx != 6) begin bad++; $display("FAIL wrap_accepted got=%0d want=6", idx); end
        total++; if (irqs != 0) begin bad++; $display("FAIL wrap_irq_between got=%0d want=0", irqs); end
    endtask

    task automatic test_reset_mid_frame();
        int irqs, txlow, busy;
        irqs = 0; txlow = 0; busy = 0;
        for (int j = 0; j < 47; j++) begin
            a_if.TX_VALID = (j < 3);
            a_if.TX_DATA  = (j == 0) ? 8'h00 : (j == 1) ? 8'h11 : 8'h22;
            @(negedge clk);
        end
        total++; if ({a_tx, a_cnt} !== {1'b0, 3'd2}) begin bad++; $display("FAIL midrst_before tx/cnt got=%b/%0d want=0/2", a_tx, a_cnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({a_tx, a_cnt, a_busy, a_irq, a_empty, a_if.TX_READY} !== {1'b1, 3'd0, 4'b0011}) begin
            bad++; $display("FAIL midrst_after tx/cnt/busy/irq/empty/rdy got=%b/%0d/%b/%b/%b/%b want=1/0/0/0/1/1",
                            a_tx, a_cnt, a_busy, a_irq, a_empty, a_if.TX_READY);
        end
        for (int k = 0; k < 300; k++) begin
            if (a_irq !== 1'b0) irqs++;
            if (a_tx !== 1'b1) txlow++;
            if (a_busy !== 1'b0) busy++;
            @(negedge clk);
        end
        total++; if (irqs != 0) begin bad++; $display("FAIL midrst_irq got=%0d want=0", irqs); end
        total++; if (txlow != 0) begin bad++; $display("FAIL midrst_tx_low_cycles got=%0d want=0", txlow); end
        total++; if (busy != 0) begin bad++; $display("FAIL midrst_busy_cycles got=%0d want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_full_wrap();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_transmit_controller.md
Name: uart_transmit_controller

Overview:
UART transmit path: the transmit-side counterpart of the UART receive controller inside AXI_UART. It accepts bytes from the AXI register side over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized as start / data (LSB first) / optional parity / stop onto TX at C_BAUDRATE. It raises a one-cycle Interrupt pulse when the transmitter drains.

Parameters:
C_S_AXI_ACLK_FREQ_HZ, 100_000_000, clock frequency in Hz
C_BAUDRATE, 9600, line rate; bit period DIV = C_S_AXI_ACLK_FREQ_HZ / C_BAUDRATE (integer truncation; 10416 at defaults; DIV >= 2 required)
C_DATA_BITS, 8, data bits per frame (5..8)
C_USE_PARITY, 0, 1 = append parity bit
C_ODD_PARITY, 0, 1 = odd parity, 0 = even (only when C_USE_PARITY=1)
C_FIFO_DEPTH, 16, TX FIFO entries (power of 2, >= 2)

Ports:
S_AXI_ACLK  in  1  clock; all logic on rising edge
S_AXI_ARESET  in  1  reset; one clock; reset is synchronous and active-high
TX_DATA  in  C_DATA_BITS  byte to send
TX_VALID  in  1  TX_DATA valid
TX_READY  out  1  FIFO can accept (= !TX_FIFO_FULL)
TX_FIFO_FULL  out  1  FIFO holds C_FIFO_DEPTH entries
TX_FIFO_EMPTY  out  1  FIFO holds 0 entries
TX_COUNT  out  $clog2(C_FIFO_DEPTH)+1  FIFO occupancy
TX_BUSY  out  1  FSM not in IDLE
Interrupt  out  1  one-cycle pulse, transmitter drained
TX  out  1  serial line, idle high, registered

Behaviour:
- Reset (sampled at edge): TX=1, TX_BUSY=0, Interrupt=0, TX_COUNT=0, TX_FIFO_EMPTY=1, TX_FIFO_FULL=0, TX_READY=1, FSM=IDLE, baud counter=0. FIFO pointers cleared, contents discarded. Reset mid-frame aborts the frame: TX high after that edge, no Interrupt.
- Push: on edge with TX_VALID & TX_READY. TX_VALID while full is ignored; data is not captured, no error flag. TX_VALID must hold with TX_DATA stable until accepted.
- Pop: FSM takes the head entry when (IDLE, or last clock of STOP) and !TX_FIFO_EMPTY.
- Simultaneous push+pop on the same edge: TX_COUNT unchanged, both take effect. Push into empty FIFO with the FSM idle: pop occurs next edge, never the same edge.
- TX_COUNT, FULL, EMPTY and TX_READY are registered/derived from registered count; valid the cycle after the edge.
- Pointers wrap modulo C_FIFO_DEPTH; count saturates logically via READY gating, never exceeds depth.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on pop. Load shift register and compute parity; TX<=0 on that edge.
  - Every bit lasts exactly DIV clocks. The baud counter runs 0..DIV-1, resets on every state or bit change.
  - START -> DATA after DIV clocks: TX<=data[0].
  - DATA shifts LSB first, bit index 0..C_DATA_BITS-1. After the last bit: PARITY if C_USE_PARITY, else STOP.
  - PARITY bit = ^data XOR C_ODD_PARITY. -> STOP after DIV clocks.
  - STOP: TX=1 for DIV clocks. Then START (back-to-back, no idle gap) if FIFO non-empty, else IDLE.
- Frame length = (2 + C_DATA_BITS + C_USE_PARITY) * DIV clocks.
- Latency: byte accepted at edge N into empty FIFO with FSM idle -> pop at edge N+1, TX falls after edge N+1.
- Interrupt: pulses high for one cycle on the edge where STOP ends and the FSM enters IDLE (FIFO empty). No pulse between back-to-back frames.
- TX_BUSY=1 in every state except IDLE.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input port TX_BREAK (1 bit). While TX_BREAK=1, TX is forced 0 and the FSM holds in IDLE (no pops). A frame in progress completes before the break takes effect; FIFO pushes continue. On deassertion, TX returns to 1 next edge; pending bytes start no earlier than DIV clocks later (one idle bit period).
- Undefined: no TX_BREAK port; behaviour as above.

Test Plan:
- Reset values: C_S_AXI_ACLK_FREQ_HZ=100, C_BAUDRATE=10 (DIV=10). After reset: TX=1, TX_READY=1, TX_COUNT=0, Interrupt=0.
- Single byte 0xA5, no parity -> TX low 10 clk, then 1,0,1,0,0,1,0,1 (10 clk each), high 10 clk. Total 100 clk. Interrupt pulses once at frame end; TX_BUSY 0 afterwards.
- Parity: C_USE_PARITY=1. Byte 0x07 with even parity -> parity bit 1; with C_ODD_PARITY=1 -> 0. Frame 110 clk.
- Back-to-back: push 0x55 then 0x0F on consecutive cycles -> second start bit immediately follows first stop bit (no gap). Single Interrupt after second frame.
- Full/wrap, C_FIFO_DEPTH=4: hold TX_VALID for 6 distinct bytes while line busy -> TX_READY drops at count 4. Extra bytes captured only after pops. All 6 bytes transmitted in order; pointers wrap correctly.
- Reset mid-frame: assert S_AXI_ARESET during DATA bit 3 of 0x00 with 2 queued -> TX=1 next edge, TX_COUNT=0, no Interrupt, no further frames.
